// File: rtl/nx_node_emitter_if.sv
// Command/payload handshake from the node emitter to the node transmitter.
// The emitter drives the master side; the transmitter answers with tx_ready.
interface nx_node_emitter_if #(
    parameter int PAYLOAD_W = 24,
    parameter int CMD_OP_W  = 2
) ();
    logic [CMD_OP_W-1:0]  tx_command;
    logic [PAYLOAD_W-1:0] tx_payload;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_command, output tx_payload, output tx_valid, input tx_ready);
    modport slave  (input tx_command, input tx_payload, input tx_valid, output tx_ready);
endinterface

// File: rtl/nx_node_emitter.sv
// Announces changed core outputs as signal-state messages, one per changed output,
// picked round-robin and offered on a registered valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no message in flight; may load the next pending output
// ST_SEND | message offered, held stable until tx_valid & tx_ready
module nx_node_emitter #(
    parameter int IO_W          = 4,
    parameter int PAYLOAD_W     = 24,
    parameter int CMD_OP_W      = 2,
    parameter int CMD_SIG_STATE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        node_id,
    input  logic [IO_W-1:0]   out_values,
    input  logic [IO_W-1:0]   out_valids,
    nx_node_emitter_if.master tx_bus,
    output logic              idle
);
    localparam int IDX_W = (IO_W > 1) ? $clog2(IO_W) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IO_W-1:0]      value_q;
    logic [IO_W-1:0]      seen_q;
    logic [IO_W-1:0]      sent_q;
    logic [IO_W-1:0]      announced_q;
    logic [IO_W-1:0]      pending;
    logic [IDX_W-1:0]     cur_q;
    logic [IDX_W-1:0]     cur_d;
    logic [IDX_W-1:0]     cur_next;
    logic [IDX_W-1:0]     rr_q;
    logic [IDX_W-1:0]     rr_d;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W:0]       scan_idx;
    logic                 sel_found;
    logic [7:0]           idx_field;
    logic [CMD_OP_W-1:0]  cmd_q;
    logic [CMD_OP_W-1:0]  cmd_d;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [PAYLOAD_W-1:0] payload_d;
    logic [PAYLOAD_W-1:0] load_payload;
    logic                 valid_q;
    logic                 valid_d;
    logic                 handshake;

    // The in-flight output is masked so it cannot be picked twice; after its
    // handshake it re-evaluates against the value just sent.
    always_comb begin
        pending = '0;
        for (int i = 0; i < IO_W; i++) begin
            pending[i] = seen_q[i]
                       & (~announced_q[i] | (value_q[i] ^ sent_q[i]))
                       & ~((state_q == ST_SEND) && (cur_q == IDX_W'(i)));
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < IO_W; k++) begin
            scan_idx = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(IO_W)) begin
                scan_idx = scan_idx - (IDX_W+1)'(IO_W);
            end
            if (!sel_found && pending[scan_idx[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        idx_field              = '0;
        idx_field[IDX_W-1:0]   = sel_idx;
        load_payload           = '0;
        load_payload[23:16]    = node_id;
        load_payload[15:8]     = idx_field;
        load_payload[0]        = value_q[sel_idx];
    end

    assign cur_next = (cur_q == IDX_W'(IO_W - 1)) ? '0 : cur_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        cmd_d     = cmd_q;
        payload_d = payload_q;
        cur_d     = cur_q;
        rr_d      = rr_q;
        handshake = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && sel_found) begin
                    cur_d     = sel_idx;
                    cmd_d     = CMD_OP_W'(CMD_SIG_STATE);
                    payload_d = load_payload;
                    valid_d   = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (valid_q && tx_bus.tx_ready) begin
                    handshake = 1'b1;
                    rr_d      = cur_next;
                    valid_d   = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            cmd_q     <= '0;
            payload_q <= '0;
            cur_q     <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            cmd_q     <= cmd_d;
            payload_q <= payload_d;
            cur_q     <= cur_d;
            rr_q      <= rr_d;
        end
    end

    // Latest strobe wins; a strobe on the in-flight index only touches value_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q     <= '0;
            seen_q      <= '0;
            sent_q      <= '0;
            announced_q <= '0;
        end else begin
            value_q <= (value_q & ~out_valids) | (out_values & out_valids);
            seen_q  <= seen_q | out_valids;
            if (handshake) begin
                sent_q[cur_q]      <= payload_q[0];
                announced_q[cur_q] <= 1'b1;
            end
        end
    end

    assign tx_bus.tx_command = cmd_q;
    assign tx_bus.tx_payload = payload_q;
    assign tx_bus.tx_valid   = valid_q;
    assign idle              = (state_q == ST_IDLE) && !(|pending);

endmodule

// File: tb/tb_nx_node_emitter.sv
// Bench for nx_node_emitter: directed scenarios against fixed expected messages,
// then randomized traffic against a per-output behavioural model.
module tb_nx_node_emitter;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] node_id;
    logic [N-1:0] out_values;
    logic [N-1:0] out_valids;
    logic       idle;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nx_node_emitter_if #(.PAYLOAD_W(24), .CMD_OP_W(2)) bus ();

    nx_node_emitter #(
        .IO_W(N), .PAYLOAD_W(24), .CMD_OP_W(2), .CMD_SIG_STATE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .node_id(node_id),
        .out_values(out_values),
        .out_valids(out_valids),
        .tx_bus(bus),
        .idle(idle)
    );

    // Behavioural model: per-output bookkeeping plus the one message in flight.
    bit          m_val[N];
    bit          m_seen[N];
    bit          m_sent[N];
    bit          m_ann[N];
    int          m_rr;
    int          m_cur;
    bit          m_inflight;
    logic [23:0] m_payload;

    function automatic bit m_pending(int i);
        return m_seen[i] && (!m_ann[i] || (m_val[i] != m_sent[i]))
               && !(m_inflight && (m_cur == i));
    endfunction

    function automatic bit m_any_pending();
        bit any = 1'b0;
        for (int i = 0; i < N; i++) if (m_pending(i)) any = 1'b1;
        return any;
    endfunction

    task automatic model_step();
        int sel;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_val[i] = 0; m_seen[i] = 0; m_sent[i] = 0; m_ann[i] = 0;
            end
            m_rr = 0; m_cur = 0; m_inflight = 0; m_payload = '0;
            return;
        end
        sel = -1;
        if (!m_inflight && enable) begin
            for (int k = 0; k < N; k++) begin
                int j = (m_rr + k) % N;
                if (sel < 0 && m_pending(j)) sel = j;
            end
        end
        if (m_inflight && bus.tx_ready) begin
            m_sent[m_cur] = m_payload[0];
            m_ann[m_cur]  = 1'b1;
            m_rr          = (m_cur + 1) % N;
            m_inflight    = 1'b0;
        end else if (sel >= 0) begin
            m_cur      = sel;
            m_payload  = {node_id, 8'(sel), 7'b0, m_val[sel]};
            m_inflight = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (out_valids[i]) begin
                m_val[i]  = out_values[i];
                m_seen[i] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [N-1:0] mask, input logic [N-1:0] vals);
        out_valids = mask;
        out_values = vals;
        tick();
        out_valids = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; bus.tx_ready = 1'b0;
        node_id = 8'h00; out_values = '0; out_valids = '0;
        tick(); tick();
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.tx_valid); end
        checks++; if (bus.tx_command !== 2'd0) begin errors++; $display("FAIL reset_cmd got=%h exp=0", bus.tx_command); end
        checks++; if (bus.tx_payload !== 24'h0) begin errors++; $display("FAIL reset_payload got=%h exp=0", bus.tx_payload); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
        rst = 1'b1;
    endtask

    task automatic test_first_message();
        enable = 1'b1; node_id = 8'h35; bus.tx_ready = 1'b0;
        strobe(4'b0100, 4'b0100);
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL first_early got=%b exp=0", bus.tx_valid); end
        tick();
        checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", bus.tx_valid); end
        checks++; if (bus.tx_payload !== 24'h350201) begin errors++; $display("FAIL first_payload got=%h exp=350201", bus.tx_payload); end
        checks++; if (bus.tx_command !== 2'd2) begin errors++; $display("FAIL first_cmd got=%h exp=2", bus.tx_command); end
        bus.tx_ready = 1'b1;
        tick();
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL first_drop got=%b exp=0", bus.tx_valid); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL first_idle got=%b exp=1", idle); end
    endtask

    task automatic test_no_resend();
        bus.tx_ready = 1'b1;
        strobe(4'b0100, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.tx_valid !== 1'b0 || idle !== 1'b1) begin
                errors++; $display("FAIL same_value valid=%b idle=%b exp valid=0 idle=1", bus.tx_valid, idle);
            end
            tick();
        end
        strobe(4'b0100, 4'b0000);
        tick();
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_payload !== 24'h350200) begin
            errors++; $display("FAIL changed_value valid=%b payload=%h exp valid=1 payload=350200", bus.tx_valid, bus.tx_payload);
        end
        tick();
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL changed_drop got=%b exp=0", bus.tx_valid); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] vals;
        logic [23:0]  exp;
        rst = 1'b0; tick(); rst = 1'b1;
        bus.tx_ready = 1'b1; enable = 1'b1;
        vals = 4'b1010;
        strobe(4'b1111, vals);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 0) begin
                exp = {8'h35, 8'(k / 2), 7'b0, vals[k / 2]};
                checks++; if (bus.tx_valid !== 1'b1 || bus.tx_payload !== exp) begin
                    errors++; $display("FAIL rr_msg%0d valid=%b payload=%h exp valid=1 payload=%h", k / 2, bus.tx_valid, bus.tx_payload, exp);
                end
            end else begin
                checks++; if (bus.tx_valid !== 1'b0) begin
                    errors++; $display("FAIL rr_gap%0d got=%b exp=0", k / 2, bus.tx_valid);
                end
            end
        end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rr_idle got=%b exp=1", idle); end
    endtask

    task automatic test_hold_followup();
        bus.tx_ready = 1'b0;
        strobe(4'b0010, 4'b0000);
        tick();
        for (int h = 0; h < 5; h++) begin
            out_valids = (h == 1) ? 4'b0010 : 4'b0000;
            out_values = 4'b0010;
            tick();
            checks++; if (bus.tx_valid !== 1'b1 || bus.tx_payload !== 24'h350100) begin
                errors++; $display("FAIL hold_stable%0d valid=%b payload=%h exp valid=1 payload=350100", h, bus.tx_valid, bus.tx_payload);
            end
        end
        out_valids = '0;
        bus.tx_ready = 1'b1;
        tick();
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL hold_drop got=%b exp=0", bus.tx_valid); end
        tick();
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_payload !== 24'h350101) begin
            errors++; $display("FAIL followup valid=%b payload=%h exp valid=1 payload=350101", bus.tx_valid, bus.tx_payload);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (bus.tx_valid !== 1'b0 || idle !== 1'b1) begin
                errors++; $display("FAIL single_followup valid=%b idle=%b exp valid=0 idle=1", bus.tx_valid, idle);
            end
        end
    endtask

    task automatic test_enable_gate();
        enable = 1'b0; bus.tx_ready = 1'b1;
        strobe(4'b0010, 4'b0010);
        strobe(4'b0010, 4'b0000);
        checks++; if (idle !== 1'b0 || bus.tx_valid !== 1'b0) begin
            errors++; $display("FAIL gate_pending idle=%b valid=%b exp idle=0 valid=0", idle, bus.tx_valid);
        end
        strobe(4'b0010, 4'b0010);
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL gate_restored got=%b exp=1", idle); end
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL gate_quiet got=%b exp=0", bus.tx_valid); end
        end
    endtask

    task automatic test_reset_in_send();
        bus.tx_ready = 1'b0; enable = 1'b1;
        strobe(4'b1000, 4'b0000);
        tick();
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_payload !== 24'h350300) begin
            errors++; $display("FAIL pre_reset valid=%b payload=%h exp valid=1 payload=350300", bus.tx_valid, bus.tx_payload);
        end
        rst = 1'b0; tick(); rst = 1'b1;
        checks++; if (bus.tx_valid !== 1'b0 || idle !== 1'b1) begin
            errors++; $display("FAIL send_reset valid=%b idle=%b exp valid=0 idle=1", bus.tx_valid, idle);
        end
        strobe(4'b1000, 4'b0000);
        tick();
        checks++; if (bus.tx_valid !== 1'b1 || bus.tx_payload !== 24'h350300) begin
            errors++; $display("FAIL post_reset valid=%b payload=%h exp valid=1 payload=350300", bus.tx_valid, bus.tx_payload);
        end
        bus.tx_ready = 1'b1;
        tick();
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL post_reset_drop got=%b exp=0", bus.tx_valid); end
    endtask

    task automatic test_random();
        bit exp_idle;
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 299) != 0);
            enable       = ($urandom_range(0, 3) != 0);
            bus.tx_ready = 1'($urandom_range(0, 1));
            node_id      = 8'($urandom);
            out_valids   = 4'($urandom & $urandom & $urandom);
            out_values   = 4'($urandom);
            tick();
            exp_idle = !m_inflight && !m_any_pending();
            checks++; if (bus.tx_valid !== m_inflight) begin
                errors++; $display("FAIL rand_valid cycle=%0d got=%b exp=%b", c, bus.tx_valid, m_inflight);
            end
            checks++; if (idle !== exp_idle) begin
                errors++; $display("FAIL rand_idle cycle=%0d got=%b exp=%b", c, idle, exp_idle);
            end
            if (m_inflight) begin
                checks++; if (bus.tx_payload !== m_payload || bus.tx_command !== 2'd2) begin
                    errors++; $display("FAIL rand_msg cycle=%0d payload=%h cmd=%h exp payload=%h cmd=2", c, bus.tx_payload, bus.tx_command, m_payload);
                end
            end
        end
        rst = 1'b1; out_valids = '0;
    endtask

    initial begin
        test_reset();
        test_first_message();
        test_no_resend();
        test_round_robin();
        test_hold_followup();
        test_enable_gate();
        test_reset_in_send();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nx_node_emitter.md
# nx_node_emitter

Output-side message generator for a Nexus node. It watches the node core's per-output value strobes and detects outputs whose state changed since last announced. It then emits one signal-state message per changed output onto the command/payload handshake that feeds the node's transmitter. It is the outbound counterpart of the receiver path, which decodes inbound signal-state messages into core input loads.

## Interface
Parameters:
- IO_W, 4, number of core outputs; legal range 1..256.
- PAYLOAD_W, 24, message payload width; fixed field layout below, must be ≥ 24.
- CMD_OP_W, 2, command field width.
- CMD_SIG_STATE, 2, command code placed on tx_command for every emitted message.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- enable  input  1  high permits starting new messages; low only stalls the start of new messages.
- node_id  input  8  identifier of this node; sampled when a message is loaded.
- out_values  input  IO_W  core output values.
- out_valids  input  IO_W  per-output strobe; bit i high means out_values[i] is a fresh value this cycle.
- tx_command  output  CMD_OP_W  message command.
- tx_payload  output  PAYLOAD_W  message payload.
- tx_valid  output  1  message offered.
- tx_ready  input  1  transmitter accepts the message when high with tx_valid.
- idle  output  1  high when nothing is pending and no message is in flight.

## Operation
- Per-output registers: value_q[i] (latest captured value), seen[i] (strobed at least once since reset), sent_q[i] (last value handed off), announced[i] (sent at least once).
- Capture: out_valids[i]=1 → value_q[i]<=out_values[i], seen[i]<=1. A strobe overwrites any earlier unsent value, so the latest value wins.
- pending[i] = seen[i] & (~announced[i] | value_q[i]!=sent_q[i]) & ~(busy & cur_idx==i). This term is combinational from registers.
- FSM states:
  - IDLE: if enable and any pending[i], select the first pending index found scanning upward from rr_ptr and wrapping modulo IO_W. Load cur_idx, tx_command=CMD_SIG_STATE, and tx_payload = {pad zeros, node_id[7:0] at [23:16], index at [15:8], zeros [7:1], value_q[cur] at [0]}. Assert tx_valid and go to SEND.
  - SEND: tx_command and tx_payload are held stable while tx_valid=1 and tx_ready=0.
  - SEND, on tx_valid & tx_ready: sent_q[cur]<=payload[0], announced[cur]<=1, rr_ptr<=(cur+1) mod IO_W, tx_valid<=0, return to IDLE.
- The next message can start at the earliest one cycle after a handshake, so throughput is at most one message per 2 cycles.
- A strobe on cur_idx during SEND updates value_q only. After the handshake, pending re-evaluates against the newly sent value, giving at most one follow-up message.
- A value that returns to sent_q before it is sent is not emitted; pending clears naturally.
- enable low in SEND: the in-flight message still completes. No new message starts until enable is high.
- idle = (state==IDLE) & ~|pending.
- Index field width: 8 bits, zero-extended from $clog2(IO_W). IO_W=1 puts index 0 in the field.

## Timing
- Reset (rst=0 at clock edge): tx_valid=0, tx_command=0, tx_payload=0, idle=1. Reset also clears state to IDLE, rr_ptr=0, and value_q, seen, sent_q and announced to all zeros.
- Reset mid-SEND drops the message and tx_valid falls on the next edge; nothing is retained.
- Latency: strobe at edge N → value_q valid after N → tx_valid high after edge N+1. This is 2 cycles from strobe to offer when IDLE and enabled.
- tx_valid does not depend combinationally on tx_ready. Once asserted, it stays high until the handshake or reset.
- Simultaneous strobes on several outputs produce messages in round-robin order starting at rr_ptr.

## Test plan
- Reset, then out_valids=4'b0100 with out_values=4'b0100 and node_id=8'h35 → after 2 cycles tx_valid=1 with payload 24'h350201. After tx_ready, idle=1.
- Re-strobe output 2 with value 1 after it was sent → no message; idle stays 1. Strobe it with 0 → one message with payload 24'h350200.
- Strobe all four outputs at once, with rr_ptr=0 and tx_ready always high → messages for indexes 0,1,2,3 in order, spaced 2 cycles apart.
- Hold tx_ready=0 for 5 cycles while an offer is up and strobe the in-flight index with a new value → payload stays stable. After the handshake, exactly one follow-up message carries the new value.
- Toggle output 1 through 1→0→1 within 3 cycles while enable=0 and output 1 was last sent as 1 → no message after enable rises.
- Assert rst low during SEND → next cycle tx_valid=0 and idle=1. A strobe of value 0 afterwards emits a message, because announced was cleared.
